wb_write_arbiter: RTL and testbench

//   Parametrised write-back arbiter that merges register-file writes from NUM_SRC producers into one RF write port.

---
 rtl/wb_write_arbiter_if.sv | 34 +++
 rtl/wb_write_arbiter.sv | 173 +++++++++++++++++
 tb/tb_wb_write_arbiter.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/wb_write_arbiter_if.sv
// Write-back arbiter bus: producer-side write offers plus the single RF write
// port and hazard/status outputs.
//   src_valid/src_ready/src_rd/src_data : per-source write offers (flat slices)
//   rf_we/rf_waddr/rf_wdata/rf_src      : register-file write port
//   pend_mask/busy                      : pending-destination mask, any-buffered
// The arbiter takes the slave modport; producers/bench take master.
interface wb_write_arbiter_if #(
  parameter int NUM_SRC = 2,
  parameter int XLEN    = 32,
  parameter int AW      = 5
);
  localparam int SW = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0]      src_valid;
  logic [NUM_SRC-1:0]      src_ready;
  logic [NUM_SRC*AW-1:0]   src_rd;
  logic [NUM_SRC*XLEN-1:0] src_data;
  logic                    rf_we;
  logic [AW-1:0]           rf_waddr;
  logic [XLEN-1:0]         rf_wdata;
  logic [SW-1:0]           rf_src;
  logic [(1<<AW)-1:0]      pend_mask;
  logic                    busy;

  modport slave (
    input  src_valid, src_rd, src_data,
    output src_ready, rf_we, rf_waddr, rf_wdata, rf_src, pend_mask, busy
  );

  modport master (
    output src_valid, src_rd, src_data,
    input  src_ready, rf_we, rf_waddr, rf_wdata, rf_src, pend_mask, busy
  );
endinterface

// File: rtl/wb_write_arbiter.sv
// Write-back arbiter: merges RF writes from NUM_SRC producers (0=MEM, 1=ALU,
// 2+=MUL/DIV...) into one RF write port. Each source owns a small FIFO so a
// losing write is buffered rather than stalling its producer.
//   clk, rst_n : clock, async active-low reset
//   bus        : wb_write_arbiter_if.slave (offers in, RF port + status out)
// Arbitration is combinational on FIFO heads; the granted head pops at the
// next rising edge. RR_MODE=0 lowest index wins, RR_MODE=1 round-robin.

// Per-source FIFO. Writes to x0 never get here (filtered by the caller).
// pend is the OR of one-hot destinations over all occupied slots.
module wb_write_arbiter_fifo #(
  parameter int XLEN  = 32,
  parameter int AW    = 5,
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic                 pop,
  input  logic [AW-1:0]        in_rd,
  input  logic [XLEN-1:0]      in_data,
  output logic                 empty,
  output logic                 full,
  output logic [AW-1:0]        head_rd,
  output logic [XLEN-1:0]      head_data,
  output logic [(1<<AW)-1:0]   pend
);
  // DEPTH=1 still gets a 1-bit pointer; it is simply held at 0.
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SLOTS = 1 << PW;
  localparam int CW    = $clog2(DEPTH + 1);

  logic [PW-1:0]   rd_ptr, wr_ptr, rd_ptr_nx, wr_ptr_nx;
  logic [CW-1:0]   count;
  logic [SLOTS-1:0] vld;
  logic [AW-1:0]   rd_q   [SLOTS];
  logic [XLEN-1:0] data_q [SLOTS];

  assign rd_ptr_nx = (DEPTH == 1) ? '0 : rd_ptr + 1'b1;
  assign wr_ptr_nx = (DEPTH == 1) ? '0 : wr_ptr + 1'b1;

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign head_rd   = rd_q[rd_ptr];
  assign head_data = data_q[rd_ptr];

  // push requires !full and pop requires !empty, so the two never touch the
  // same slot in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      vld    <= '0;
    end else begin
      if (push) begin
        wr_ptr      <= wr_ptr_nx;
        vld[wr_ptr] <= 1'b1;
      end
      if (pop) begin
        rd_ptr      <= rd_ptr_nx;
        vld[rd_ptr] <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload needs no reset: vld/count gate every use of it.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_q[wr_ptr]   <= in_rd;
      data_q[wr_ptr] <= in_data;
    end
  end

  always_comb begin
    pend = '0;
    for (int j = 0; j < SLOTS; j++)
      if (vld[j]) pend[rd_q[j]] = 1'b1;
    pend[0] = 1'b0;
  end
endmodule

module wb_write_arbiter #(
  parameter int NUM_SRC = 2,
  parameter int XLEN    = 32,
  parameter int AW      = 5,
  parameter int DEPTH   = 2,
  parameter int RR_MODE = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  wb_write_arbiter_if.slave  bus
);
  localparam int SW = $clog2(NUM_SRC);
  localparam int NR = 1 << AW;

  logic [NUM_SRC-1:0]           empty, full, push, pop;
  logic [NUM_SRC-1:0][AW-1:0]   in_rd, head_rd;
  logic [NUM_SRC-1:0][XLEN-1:0] in_data, head_data;
  logic [NUM_SRC-1:0][NR-1:0]   pend;
  logic [SW-1:0]                rr_ptr, gnt;
  logic                         gnt_vld;

  assign in_rd   = bus.src_rd;
  assign in_data = bus.src_data;

  // Ready is plain !full: a same-cycle pop is not credited.
  // x0 writes are acknowledged but dropped before the FIFO.
  always_comb begin
    push = '0;
    for (int i = 0; i < NUM_SRC; i++)
      push[i] = bus.src_valid[i] & ~full[i] & (in_rd[i] != '0);
  end

  wb_write_arbiter_fifo #(.XLEN(XLEN), .AW(AW), .DEPTH(DEPTH)) u_fifo [NUM_SRC-1:0] (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .in_rd     (in_rd),
    .in_data   (in_data),
    .empty     (empty),
    .full      (full),
    .head_rd   (head_rd),
    .head_data (head_data),
    .pend      (pend)
  );

  // Search order: from 0 (fixed) or from rr_ptr wrapping (round-robin).
  always_comb begin
    int idx;
    idx     = 0;
    gnt_vld = 1'b0;
    gnt     = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = (RR_MODE != 0) ? (int'(rr_ptr) + k) % NUM_SRC : k;
      if (!gnt_vld && !empty[idx]) begin
        gnt_vld = 1'b1;
        gnt     = SW'(idx);
      end
    end
  end

  always_comb begin
    pop = '0;
    if (gnt_vld) pop[gnt] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rr_ptr <= '0;
    else if (gnt_vld)
      rr_ptr <= (gnt == SW'(NUM_SRC - 1)) ? '0 : gnt + 1'b1;
  end

  always_comb begin
    bus.pend_mask = '0;
    for (int i = 0; i < NUM_SRC; i++)
      bus.pend_mask = bus.pend_mask | pend[i];
  end

  assign bus.src_ready = ~full;
  assign bus.busy      = |(~empty);
  assign bus.rf_we     = gnt_vld;
  assign bus.rf_src    = gnt;
  assign bus.rf_waddr  = gnt_vld ? head_rd[gnt]   : '0;
  assign bus.rf_wdata  = gnt_vld ? head_data[gnt] : '0;
endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter: one fixed-priority and one round-robin
// instance (NUM_SRC=2, XLEN=32, AW=5, DEPTH=2). Inputs are driven and outputs
// sampled on the falling clock edge.
module tb_wb_write_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_write_arbiter_if #(.NUM_SRC(2), .XLEN(32), .AW(5)) fx ();
  wb_write_arbiter_if #(.NUM_SRC(2), .XLEN(32), .AW(5)) rr ();

  wb_write_arbiter #(.NUM_SRC(2), .XLEN(32), .AW(5), .DEPTH(2), .RR_MODE(0)) dut_fx (
    .clk(clk), .rst_n(rst_n), .bus(fx));
  wb_write_arbiter #(.NUM_SRC(2), .XLEN(32), .AW(5), .DEPTH(2), .RR_MODE(1)) dut_rr (
    .clk(clk), .rst_n(rst_n), .bus(rr));

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drv_fx(input int s, input logic v, input logic [4:0] rd, input logic [31:0] d);
    fx.src_valid[s]         = v;
    fx.src_rd[s*5 +: 5]     = rd;
    fx.src_data[s*32 +: 32] = d;
  endtask

  task automatic drv_rr(input int s, input logic v, input logic [4:0] rd, input logic [31:0] d);
    rr.src_valid[s]         = v;
    rr.src_rd[s*5 +: 5]     = rd;
    rr.src_data[s*32 +: 32] = d;
  endtask

  task automatic idle();
    fx.src_valid = '0; fx.src_rd = '0; fx.src_data = '0;
    rr.src_valid = '0; rr.src_rd = '0; rr.src_data = '0;
  endtask

  // Watchdog: the stimulus below is bounded, this only guards a hang.
  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] q0[$], q1[$];
    logic [63:0] got, exp;
    int n0, n1, commits, es;

    idle();
    // ---- reset values
    @(negedge clk);
    chk("rst_we",    fx.rf_we, 0);
    chk("rst_busy",  fx.busy, 0);
    chk("rst_pend",  fx.pend_mask, 0);
    chk("rst_ready", fx.src_ready, 2'b11);
    chk("rst_addr",  {fx.rf_waddr, fx.rf_wdata, fx.rf_src}, 0);
    chk("rst_rr",    {rr.rf_we, rr.busy, rr.src_ready}, 4'b0011);
    rst_n = 1'b1;
    @(negedge clk);

    // ---- 1: collision, fixed priority
    drv_fx(0, 1, 5'd5, 32'hAAAA);
    drv_fx(1, 1, 5'd6, 32'hBBBB);
    @(negedge clk);
    idle();
    chk("t1_c1", {fx.rf_we, fx.rf_waddr, fx.rf_wdata, fx.rf_src}, {1'b1, 5'd5, 32'hAAAA, 1'b0});
    chk("t1_pend", fx.pend_mask, 32'h0000_0060);
    @(negedge clk);
    chk("t1_c2", {fx.rf_we, fx.rf_waddr, fx.rf_wdata, fx.rf_src}, {1'b1, 5'd6, 32'hBBBB, 1'b1});
    @(negedge clk);
    chk("t1_c3", {fx.rf_we, fx.busy}, 2'b00);

    // ---- 2: backpressure with scoreboard
    n0 = 0; n1 = 0; commits = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (fx.rf_we) begin
        got = {27'b0, fx.rf_waddr, fx.rf_wdata};
        if (fx.rf_src == 1'b0 && q0.size() > 0)      exp = q0.pop_front();
        else if (fx.rf_src == 1'b1 && q1.size() > 0) exp = q1.pop_front();
        else                                          exp = '1;
        chk("t2_commit", got, exp);
        if (fx.rf_src == 1'b1) chk("t2_src1_after_src0", 64'(cyc >= 7), 1);
        commits++;
      end
      if (cyc == 1) chk("t2_ready1_hi", fx.src_ready[1], 1);
      if (cyc == 2) chk("t2_ready1_drop", fx.src_ready[1], 0);
      if (n0 == 6 && n1 == 3 && !fx.busy) break;
      idle();
      if (cyc < 6) begin
        drv_fx(0, 1, 5'(8 + n0), 32'h1000 + n0);
        if (fx.src_ready[0]) begin q0.push_back({27'b0, 5'(8 + n0), 32'h1000 + n0}); n0++; end
      end
      if (n1 < 3) begin
        drv_fx(1, 1, 5'(20 + n1), 32'h2000 + n1);
        if (fx.src_ready[1]) begin q1.push_back({27'b0, 5'(20 + n1), 32'h2000 + n1}); n1++; end
      end
      @(negedge clk);
    end
    idle();
    chk("t2_commits", commits, 9);
    chk("t2_left", q0.size() + q1.size(), 0);

    // ---- 4: x0 write dropped
    chk("t4_ready_pre", fx.src_ready[1], 1);
    drv_fx(1, 1, 5'd0, 32'hFFFF_FFFF);
    @(negedge clk);
    idle();
    chk("t4_ready", fx.src_ready[1], 1);
    chk("t4_out", {fx.rf_we, fx.busy, fx.pend_mask}, 0);
    @(negedge clk);
    chk("t4_out2", {fx.rf_we, fx.busy}, 0);

    // ---- 5: pend_mask tracks rd=7 behind src0
    drv_fx(0, 1, 5'd3, 32'h33);
    drv_fx(1, 1, 5'd7, 32'h77);
    @(negedge clk);
    idle();
    chk("t5_pend_a", fx.pend_mask, 32'h0000_0088);
    drv_fx(0, 1, 5'd4, 32'h44);
    @(negedge clk);
    idle();
    chk("t5_pend_b", fx.pend_mask[7], 1);
    chk("t5_head_b", {fx.rf_waddr, fx.rf_src}, {5'd4, 1'b0});
    @(negedge clk);
    chk("t5_pend_c", fx.pend_mask[7], 1);
    chk("t5_head_c", {fx.rf_waddr, fx.rf_wdata, fx.rf_src}, {5'd7, 32'h77, 1'b1});
    @(negedge clk);
    chk("t5_pend_d", fx.pend_mask, 0);

    // ---- 3: round-robin alternation with scoreboard
    n0 = 0; n1 = 0; es = 0; q0.delete(); q1.delete();
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (rr.rf_we) begin
        got = {27'b0, rr.rf_waddr, rr.rf_wdata};
        if (rr.rf_src == 1'b0 && q0.size() > 0)      exp = q0.pop_front();
        else if (rr.rf_src == 1'b1 && q1.size() > 0) exp = q1.pop_front();
        else                                          exp = '1;
        chk("t3_data", got, exp);
        if (cyc <= 10) begin
          chk("t3_alt", rr.rf_src, 64'(es));
          es ^= 1;
        end
      end
      if (cyc >= 10 && !rr.busy) break;
      idle();
      if (cyc < 10) begin
        drv_rr(0, 1, 5'(1 + n0 % 4), 32'h100 + n0);
        if (rr.src_ready[0]) begin q0.push_back({27'b0, 5'(1 + n0 % 4), 32'h100 + n0}); n0++; end
        drv_rr(1, 1, 5'(16 + n1 % 4), 32'h200 + n1);
        if (rr.src_ready[1]) begin q1.push_back({27'b0, 5'(16 + n1 % 4), 32'h200 + n1}); n1++; end
      end
      @(negedge clk);
    end
    idle();
    chk("t3_left", q0.size() + q1.size(), 0);

    // ---- 6: async reset mid-op. One pop per cycle means both FIFOs can't be
    // full together at DEPTH=2, so fill src1 and keep src0 occupied.
    drv_fx(0, 1, 5'd10, 32'hA0);
    drv_fx(1, 1, 5'd11, 32'hB0);
    @(negedge clk);
    drv_fx(0, 1, 5'd12, 32'hA1);
    drv_fx(1, 1, 5'd13, 32'hB1);
    @(negedge clk);
    idle();
    chk("t6_full", {fx.src_ready, fx.busy}, 3'b011);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async", {fx.rf_we, fx.busy, fx.src_ready, fx.rf_src}, 5'b00110);
    chk("t6_async_bus", {fx.rf_waddr, fx.rf_wdata, fx.pend_mask}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("t6_post", {fx.rf_we, fx.busy, fx.pend_mask}, 0);
    drv_fx(1, 1, 5'd9, 32'h1234);
    @(negedge clk);
    idle();
    chk("t6_write", {fx.rf_we, fx.rf_waddr, fx.rf_wdata, fx.rf_src}, {1'b1, 5'd9, 32'h1234, 1'b1});
    @(negedge clk);
    chk("t6_nostale", {fx.rf_we, fx.busy}, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
